// File: rtl/pm_sched_pkg.sv
// Shared types and default sizing for the decode scheduler.
package pm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } sched_state_t;

  localparam int NREQ_DEF   = 4;
  localparam int WORD_W_DEF = 16;
  localparam int RES_W_DEF  = 13;

endpackage

// File: rtl/pm_decode_scheduler_rr_arbiter.sv
// Round-robin selector: first valid requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N     = pm_sched_pkg::NREQ_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  int               w_k;

  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int i = 0; i < N; i++) begin
      w_k = (int'(ptr_i) + i) % N;
      if (!w_found && valid_i[w_k]) begin
        w_grant[w_k] = 1'b1;
        w_idx        = IDX_W'(w_k);
        w_found      = 1'b1;
      end
    end
  end

  assign grant_o = w_grant;
  assign idx_o   = w_idx;
  assign any_o   = w_found;

endmodule

// File: rtl/pm_decode_scheduler.sv
// Shares one external combinational decode unit among NREQ requesters.
// state   | meaning
// IDLE    | waiting for a request; grant is combinational from rr_ptr
// ISSUE   | dec_word_o presented to the decode unit for one cycle
// RESPOND | result held for the owning requester until it accepts
module pm_decode_scheduler
  import pm_sched_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int RES_W  = RES_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*WORD_W-1:0] req_word_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic [WORD_W-1:0]      dec_word_o,
  input  logic [RES_W-1:0]       dec_result_i,
  output logic [NREQ-1:0]        rsp_valid_o,
  input  logic [NREQ-1:0]        rsp_ready_i,
  output logic [RES_W-1:0]       rsp_result_o,
  output logic                   busy_o,
  output logic [15:0]            op_count_o
);

  localparam int IDX_W = $clog2(NREQ);

  sched_state_t     r_state, w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_id_q;
  logic [WORD_W-1:0] r_dec_word;
  logic [RES_W-1:0] r_rsp_result;
  logic [15:0]      r_op_count;

  logic [NREQ-1:0]  w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_grant_en;
  logic             w_rsp_done;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [WORD_W-1:0] w_sel_word;

  rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_arb (
    .valid_i (req_valid_i),
    .ptr_i   (r_rr_ptr),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .any_o   (w_any)
  );

  assign w_sel_word = req_word_i[int'(w_idx)*WORD_W +: WORD_W];
  assign w_ptr_nxt  = (w_idx == IDX_W'(NREQ-1)) ? '0 : w_idx + 1'b1;
  assign w_rsp_done = (r_state == RESPOND) && rsp_ready_i[r_id_q];

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_en  = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE:   w_state_nxt = RESPOND;
      RESPOND: if (w_rsp_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_id_q       <= '0;
      r_dec_word   <= '0;
      r_rsp_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_en) begin
        r_dec_word <= w_sel_word;
        r_id_q     <= w_idx;
        r_rr_ptr   <= w_ptr_nxt;
      end
      if (r_state == ISSUE) r_rsp_result <= dec_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_rsp_done && (r_op_count != 16'hFFFF)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  // Gate with rst_n so the handshake outputs are quiet for the whole reset pulse.
  assign req_ready_o  = (w_grant_en && rst_n) ? w_grant : '0;
  assign rsp_valid_o  = ((r_state == RESPOND) && rst_n) ? (NREQ'(1) << r_id_q) : '0;
  assign busy_o       = rst_n && (r_state != IDLE);
  assign dec_word_o   = r_dec_word;
  assign rsp_result_o = r_rsp_result;
  assign op_count_o   = r_op_count;

endmodule

// File: tb/tb_pm_decode_scheduler.sv
// Randomized bench for pm_decode_scheduler with a queue-free round-robin reference model.
module tb_pm_decode_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_word;
  logic [3:0]  req_ready;
  logic [15:0] dec_word;
  logic [12:0] dec_result;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [12:0] rsp_result;
  logic        busy;
  logic [15:0] op_count;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  int          m_ptr;
  int          m_cnt;
  logic [15:0] w [4];
  logic [12:0] obs_result;

  pm_decode_scheduler #(.NREQ(4), .WORD_W(16), .RES_W(13)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_word_i   (req_word),
    .req_ready_o  (req_ready),
    .dec_word_o   (dec_word),
    .dec_result_i (dec_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .busy_o       (busy),
    .op_count_o   (op_count)
  );

  assign dec_result = ~dec_word[12:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_pick(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic pack_words();
    for (int r = 0; r < 4; r++) req_word[r*16 +: 16] = w[r];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_cnt = 0;
  endtask

  // One full transaction from IDLE; caller fills w[] beforehand.
  task automatic do_txn(input logic [3:0] vmask, input int stall);
    int          win;
    logic [3:0]  oh;
    logic [12:0] exp_res;
    @(negedge clk);
    pack_words();
    req_valid = vmask;
    rsp_ready = 4'hF;
    #1;
    win = model_pick(vmask, m_ptr);
    oh  = 4'b0001 << win;
    exp_res = ~w[win][12:0];
    tot_cnt++;
    if (req_ready !== oh) $display("FAIL grant: req_ready=%b want %b", req_ready, oh);
    else pass_cnt++;
    tot_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_busy: busy=%b want 0", busy);
    else pass_cnt++;

    @(negedge clk);
    for (int r = 0; r < 4; r++) if (r != win) w[r] = 16'($urandom);
    pack_words();
    rsp_ready = (stall > 0) ? ~oh : 4'hF;
    #1;
    tot_cnt++;
    if (dec_word !== w[win] || busy !== 1'b1 || req_ready !== 4'b0 || rsp_valid !== 4'b0)
      $display("FAIL issue: dec_word=%h busy=%b rdy=%b rv=%b want %h 1 0000 0000",
               dec_word, busy, req_ready, rsp_valid, w[win]);
    else pass_cnt++;

    @(negedge clk);
    #1;
    obs_result = rsp_result;
    tot_cnt++;
    if (rsp_valid !== oh || rsp_result !== exp_res)
      $display("FAIL respond: rv=%b res=%h want %b %h", rsp_valid, rsp_result, oh, exp_res);
    else pass_cnt++;

    for (int s = 1; s <= stall; s++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      rsp_ready = ~oh;
      #1;
      tot_cnt++;
      if (rsp_valid !== oh || rsp_result !== exp_res || req_ready !== 4'b0 || busy !== 1'b1)
        $display("FAIL stall%0d: rv=%b res=%h rdy=%b busy=%b want %b %h 0000 1",
                 s, rsp_valid, rsp_result, req_ready, busy, oh, exp_res);
      else pass_cnt++;
      if (s == stall) rsp_ready = 4'hF;
    end

    @(negedge clk);
    req_valid = '0;
    rsp_ready = '0;
    #1;
    m_ptr = (win + 1) % 4;
    if (m_cnt < 65535) m_cnt++;
    tot_cnt++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0 || op_count !== 16'(m_cnt))
      $display("FAIL done: busy=%b rv=%b cnt=%h want 0 0000 %h", busy, rsp_valid, op_count, 16'(m_cnt));
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 4'hF;
    for (int r = 0; r < 4; r++) w[r] = 16'($urandom);
    pack_words();
    repeat (2) @(negedge clk);
    #1;
    tot_cnt++;
    if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || busy !== 1'b0)
      $display("FAIL reset_comb: rdy=%b rv=%b busy=%b want 0", req_ready, rsp_valid, busy);
    else pass_cnt++;
    tot_cnt++;
    if (dec_word !== 16'h0 || rsp_result !== 13'h0 || op_count !== 16'h0)
      $display("FAIL reset_regs: dw=%h res=%h cnt=%h want 0", dec_word, rsp_result, op_count);
    else pass_cnt++;
    rst_n = 1'b1; req_valid = '0; rsp_ready = '0;
    m_ptr = 0; m_cnt = 0;
  endtask

  task automatic test_single();
    for (int r = 0; r < 4; r++) w[r] = 16'($urandom);
    w[2] = 16'hA5F0;
    do_txn(4'b0100, 0);
    tot_cnt++;
    if (obs_result !== 13'h1A0F || op_count !== 16'd1)
      $display("FAIL single: res=%h cnt=%h want 1a0f 0001", obs_result, op_count);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 4; r++) w[r] = 16'($urandom);
      do_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 4; r++) w[r] = 16'($urandom);
    do_txn(4'($urandom_range(1, 15)), 5);
  endtask

  task automatic test_rotation();
    int gidx [5];
    int gcyc [5];
    int ng;
    apply_reset();
    for (int r = 0; r < 4; r++) w[r] = 16'($urandom);
    pack_words();
    req_valid = 4'hF; rsp_ready = 4'hF;
    ng = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (req_ready !== 4'b0 && ng < 5) begin
        gidx[ng] = -1;
        for (int r = 0; r < 4; r++) if (req_ready[r]) gidx[ng] = r;
        gcyc[ng] = cyc;
        ng++;
      end
    end
    tot_cnt++;
    if (ng != 5) $display("FAIL rotation_count: grants=%0d want 5", ng);
    else pass_cnt++;
    for (int g = 0; g < ng; g++) begin
      tot_cnt++;
      if (gidx[g] != m_ptr) $display("FAIL rotation_order%0d: idx=%0d want %0d", g, gidx[g], m_ptr);
      else pass_cnt++;
      m_ptr = (m_ptr + 1) % 4;
      if (g > 0) begin
        tot_cnt++;
        if (gcyc[g] - gcyc[g-1] != 3)
          $display("FAIL rotation_spacing%0d: gap=%0d want 3", g, gcyc[g] - gcyc[g-1]);
        else pass_cnt++;
      end
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_issue();
    for (int r = 0; r < 4; r++) w[r] = 16'($urandom);
    do_txn(4'b0010, 0);
    @(negedge clk);
    pack_words();
    req_valid = 4'b0100; rsp_ready = 4'hF;
    @(negedge clk);
    #1;
    tot_cnt++;
    if (busy !== 1'b1) $display("FAIL mid_setup: busy=%b want 1", busy);
    else pass_cnt++;
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    tot_cnt++;
    if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || busy !== 1'b0 || dec_word !== 16'h0 ||
        rsp_result !== 13'h0 || op_count !== 16'h0)
      $display("FAIL mid_reset: rdy=%b rv=%b busy=%b dw=%h res=%h cnt=%h want all 0",
               req_ready, rsp_valid, busy, dec_word, rsp_result, op_count);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_cnt = 0;
    #1;
    tot_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL mid_regrant: rdy=%b want 0001", req_ready);
    else pass_cnt++;
    req_valid = '0;
    repeat (4) begin
      @(negedge clk);
      #1;
      tot_cnt++;
      if (rsp_valid !== 4'b0 || busy !== 1'b0 || op_count !== 16'h0)
        $display("FAIL mid_quiet: rv=%b busy=%b cnt=%h want 0", rsp_valid, busy, op_count);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.r_op_count = 16'hFFFE;
    #1;
    release dut.r_op_count;
    m_cnt = 65534;
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < 4; r++) w[r] = 16'($urandom);
      do_txn(4'($urandom_range(1, 15)), 0);
    end
    tot_cnt++;
    if (op_count !== 16'hFFFF) $display("FAIL saturate: cnt=%h want ffff", op_count);
    else pass_cnt++;
  endtask

  initial begin
    req_valid = '0; req_word = '0; rsp_ready = '0; rst_n = 1'b0;
    test_reset();
    test_single();
    test_random();
    test_backpressure();
    test_rotation();
    test_reset_mid_issue();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
